// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI-to-memory bridge.
// Contents: FSM state encoding, 2-bit command codes, status register bit
// positions and the status register width.
package spi_mem_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_WDATA,
      ST_RDUMMY,
      ST_RDATA,
      ST_SDUMMY,
      ST_SDATA,
      ST_DROP
   } spi_mem_state_e;

   localparam logic [1:0] CMD_WRITE  = 2'b00;
   localparam logic [1:0] CMD_READ   = 2'b01;
   localparam logic [1:0] CMD_STATUS = 2'b10;
   localparam logic [1:0] CMD_RSVD   = 2'b11;

   localparam int STATUS_W     = 8;
   localparam int STAT_WRAP    = 0;  // address wrapped max->0 inside a burst
   localparam int STAT_RSVD    = 1;  // reserved command received
   localparam int STAT_PARTIAL = 2;  // WRITE frame ended mid-word

endpackage

// File: rtl/spi_mem_ram.sv
// Single-port DW x 2^AW RAM: synchronous write, registered one-cycle read.
// Ports:
//   clk    system clock
//   we     write enable, writes wdata to mem[addr] on the rising edge
//   addr   word address (shared by read and write)
//   wdata  write data
//   rdata  mem[addr] as sampled on the previous rising edge (read-first)
module spi_mem_ram #(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // NOTE: the array and the read register carry no reset so the tools can
   // map them onto block RAM; contents survive a bridge reset.
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI slave to memory bridge with burst transfers. MOSI and SS_n are sampled
// on the system clock. A frame is CMD (2 bits), ADDR (AW bits, WRITE/READ
// only) and then any number of payload bits; the address auto-increments
// once per data word. A sticky 8-bit status register is readable over SPI.
// Ports:
//   clk   system clock, all activity on the rising edge
//   rst   synchronous active-high reset, priority over SS_n/MOSI
//   SS_n  slave select, active low; high at any edge returns to IDLE
//   MOSI  serial data in, MSB first
//   MISO  serial data out, MSB first, registered
//   busy  high whenever the FSM is not in IDLE
module spi_mem_bridge
   import spi_mem_pkg::*;
#(
   parameter int DW = 8,
   parameter int AW = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic MOSI,
   output logic MISO,
   output logic busy
);

   // One bit counter serves the address, data word and status fields.
   localparam int MAX_DA = (DW > AW) ? DW : AW;
   localparam int MAX_W  = (MAX_DA > STATUS_W) ? MAX_DA : STATUS_W;
   localparam int CNT_W  = $clog2(MAX_W);

   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DW - 1);
   localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(AW - 1);
   localparam logic [CNT_W-1:0] LAST_STAT = CNT_W'(STATUS_W - 1);
   localparam logic [AW-1:0]    ADDR_MAX  = '1;

   spi_mem_state_e      state_q, state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          cmd_q;
   logic [1:0]          cmd_full;
   logic [AW-1:0]       addr_q;
   logic [DW-1:0]       rx_sr;
   logic [DW-1:0]       tx_sr;
   logic [STATUS_W-1:0] stat_sr;
   logic [STATUS_W-1:0] status_q;
   logic [STATUS_W-1:0] status_set;
   logic                status_clr;
   logic                miso_q;
   logic                ram_we;
   logic [DW-1:0]       ram_wdata;
   logic [DW-1:0]       ram_rdata;

   spi_mem_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (addr_q),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign MISO = miso_q;
   assign busy = (state_q != ST_IDLE);

   // In CMD the first command bit is already in cmd_q[0]; MOSI is CMD[0].
   assign cmd_full = {cmd_q[0], MOSI};

   // ---------------- FSM state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = ST_CMD;
         ST_CMD: begin
            case (cmd_full)
               CMD_WRITE, CMD_READ: state_d = ST_ADDR;
               CMD_STATUS:          state_d = ST_SDUMMY;
               default:             state_d = ST_DROP;
            endcase
         end
         ST_ADDR:   if (cnt_q == LAST_ADDR)
                       state_d = (cmd_q == CMD_READ) ? ST_RDUMMY : ST_WDATA;
         ST_WDATA:  state_d = ST_WDATA;
         ST_RDUMMY: state_d = ST_RDATA;
         ST_RDATA:  state_d = ST_RDATA;
         ST_SDUMMY: state_d = ST_SDATA;
         ST_SDATA:  if (cnt_q == LAST_STAT) state_d = ST_DROP;
         ST_DROP:   state_d = ST_DROP;
         default:   state_d = ST_IDLE;
      endcase
      // Deselect wins in every state; IDLE simply stays put.
      if (SS_n) state_d = ST_IDLE;
   end

   // ---------------- Memory write and status events ----------------
   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      ram_wdata  = (rx_sr << 1) | DW'(MOSI);
      ram_we     = 1'b0;
      status_clr = 1'b0;
      status_set = '0;
      if (!rst && !SS_n) begin
         case (state_q)
            ST_CMD:
               if (cmd_full == CMD_RSVD) status_set[STAT_RSVD] = 1'b1;
            ST_WDATA:
               if (cnt_q == LAST_DATA) begin
                  ram_we = 1'b1;
                  if (addr_q == ADDR_MAX) status_set[STAT_WRAP] = 1'b1;
               end
            // Read address advances at the first bit of each word (prefetch).
            ST_RDATA:
               if (cnt_q == '0 && addr_q == ADDR_MAX) status_set[STAT_WRAP] = 1'b1;
            ST_SDATA:
               if (cnt_q == LAST_STAT) status_clr = 1'b1;
            default: ;
         endcase
      end
      if (!rst && SS_n && state_q == ST_WDATA && cnt_q != '0)
         status_set[STAT_PARTIAL] = 1'b1;
   end

   // ---------------- Datapath ----------------
   // NOTE: all registers here use non-blocking assignments so every read in
   // this block sees the pre-edge value regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         cmd_q    <= '0;
         addr_q   <= '0;
         rx_sr    <= '0;
         tx_sr    <= '0;
         stat_sr  <= '0;
         status_q <= '0;
         miso_q   <= 1'b0;
      end else begin
         // A set event on the clearing edge survives the clear.
         status_q <= (status_clr ? '0 : status_q) | status_set;
         miso_q   <= 1'b0;
         if (SS_n) begin
            cnt_q <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cmd_q <= {1'b0, MOSI};
                  cnt_q <= '0;
               end
               ST_CMD: begin
                  cmd_q <= cmd_full;
                  cnt_q <= '0;
               end
               ST_ADDR: begin
                  addr_q <= (addr_q << 1) | AW'(MOSI);
                  cnt_q  <= (cnt_q == LAST_ADDR) ? '0 : cnt_q + CNT_W'(1);
               end
               ST_WDATA: begin
                  rx_sr <= ram_wdata;
                  if (cnt_q == LAST_DATA) begin
                     cnt_q  <= '0;
                     addr_q <= addr_q + AW'(1);
                  end else begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end
               end
               ST_RDUMMY: cnt_q <= '0;
               ST_RDATA: begin
                  // First bit comes straight from the RAM; the rest shift out
                  // while the RAM fetches the following word.
                  if (cnt_q == '0) begin
                     miso_q <= ram_rdata[DW-1];
                     tx_sr  <= ram_rdata << 1;
                     addr_q <= addr_q + AW'(1);
                  end else begin
                     miso_q <= tx_sr[DW-1];
                     tx_sr  <= tx_sr << 1;
                  end
                  cnt_q <= (cnt_q == LAST_DATA) ? '0 : cnt_q + CNT_W'(1);
               end
               ST_SDUMMY: begin
                  stat_sr <= status_q;
                  cnt_q   <= '0;
               end
               ST_SDATA: begin
                  miso_q  <= stat_sr[STATUS_W-1];
                  stat_sr <= stat_sr << 1;
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Self-checking bench for spi_mem_bridge (DW=8, AW=8): reset checks, a table
// of directed frames, a reset-during-read sequence and randomized write /
// read-back bursts against an array model of the memory and status bits.
module tb_spi_mem_bridge;
   import spi_mem_pkg::*;

   logic clk = 1'b0;
   logic rst, SS_n, MOSI;
   logic MISO, busy;

   int n_cmp = 0;
   int n_mis = 0;

   spi_mem_bridge #(.DW(8), .AW(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .SS_n (SS_n),
      .MOSI (MOSI),
      .MISO (MISO),
      .busy (busy)
   );

   always #5 clk = ~clk;

   // mode: 0 = no payload check, 1 = compare MISO stream, 2 = MISO must stay 0
   typedef struct {
      string       name;
      logic [1:0]  cmd;
      logic [7:0]  addr;
      int          nbits;
      logic [63:0] mosi;
      int          mode;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[$];

   // Reference model: memory contents and sticky status, by spec rules.
   logic [7:0] model_mem [256];
   logic [7:0] model_status;

   function automatic vec_t mk(input string name, input logic [1:0] cmd,
                               input logic [7:0] addr, input int nbits,
                               input logic [63:0] mosi, input int mode,
                               input logic [63:0] exp);
      vec_t v;
      v.name = name; v.cmd = cmd; v.addr = addr; v.nbits = nbits;
      v.mosi = mosi; v.mode = mode; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs just after an edge, then wait for the next rising edge and
   // settle 1 time unit so outputs updated at that edge can be sampled.
   task automatic tick(input logic r, input logic ss, input logic mi);
      rst = r; SS_n = ss; MOSI = mi;
      @(posedge clk);
      #1;
   endtask

   // One complete frame. rx collects MISO after payload edges 1..nbits-1
   // (payload edge 0 is the dummy edge); any_hi flags any high MISO.
   task automatic frame(input logic [1:0] cmd, input logic [7:0] addr,
                        input int nbits, input logic [63:0] mosi,
                        output logic [63:0] rx, output logic any_hi);
      rx = '0;
      any_hi = 1'b0;
      tick(1'b0, 1'b0, cmd[1]);
      check("busy_rise", 64'(busy), 64'd1);
      tick(1'b0, 1'b0, cmd[0]);
      if (cmd == CMD_WRITE || cmd == CMD_READ)
         for (int i = 7; i >= 0; i--) tick(1'b0, 1'b0, addr[i]);
      for (int p = 0; p < nbits; p++) begin
         tick(1'b0, 1'b0, mosi[nbits-1-p]);
         any_hi |= MISO;
         if (p > 0) rx = {rx[62:0], MISO};
      end
      tick(1'b0, 1'b1, 1'b0);
      check("busy_fall", 64'(busy), 64'd0);
      check("miso_idle", 64'(MISO), 64'd0);
   endtask

   initial begin
      logic [63:0] rx;
      logic        any_hi;

      // ---------------- Reset ----------------
      tick(1'b1, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 1'b1);   // start a STATUS frame so reset leaves a busy FSM
      tick(1'b0, 1'b0, 1'b0);
      check("busy_pre_rst", 64'(busy), 64'd1);
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         check("rst_miso", 64'(MISO), 64'd0);
         check("rst_busy", 64'(busy), 64'd0);
      end
      tick(1'b0, 1'b1, 1'b0);

      // ---------------- Directed frames ----------------
      vecs.push_back(mk("st_after_rst", CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h00));
      vecs.push_back(mk("wr_10",        CMD_WRITE,  8'h10, 16, 64'hA53C,  0, 64'h0));
      vecs.push_back(mk("st_after_wr",  CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h00));
      vecs.push_back(mk("rd_10",        CMD_READ,   8'h10, 17, 64'h0,     1, 64'hA53C));
      vecs.push_back(mk("wr_ff_wrap",   CMD_WRITE,  8'hFF, 16, 64'h1122,  0, 64'h0));
      vecs.push_back(mk("st_wrap",      CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h01));
      vecs.push_back(mk("st_wrap_clr",  CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h00));
      vecs.push_back(mk("rd_ff_wrap",   CMD_READ,   8'hFF, 17, 64'h0,     1, 64'h1122));
      vecs.push_back(mk("st_rd_wrap",   CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h01));
      vecs.push_back(mk("st_clr2",      CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h00));
      vecs.push_back(mk("wr_20_init",   CMD_WRITE,  8'h20, 16, 64'h005A,  0, 64'h0));
      vecs.push_back(mk("wr_20_part",   CMD_WRITE,  8'h20, 11, 64'h3BD,   0, 64'h0));
      vecs.push_back(mk("rd_20",        CMD_READ,   8'h20, 17, 64'h0,     1, 64'h775A));
      vecs.push_back(mk("st_partial",   CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h04));
      vecs.push_back(mk("rsvd_quiet",   CMD_RSVD,   8'h00, 16, 64'hFFFF,  2, 64'h0));
      vecs.push_back(mk("st_rsvd",      CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h02));
      vecs.push_back(mk("st_rsvd_clr",  CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h00));
      vecs.push_back(mk("wr_40_part",   CMD_WRITE,  8'h40,  5, 64'h15,    0, 64'h0));
      vecs.push_back(mk("rsvd_short",   CMD_RSVD,   8'h00,  4, 64'hF,     2, 64'h0));
      vecs.push_back(mk("st_both",      CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h06));
      vecs.push_back(mk("st_both_clr",  CMD_STATUS, 8'h00,  9, 64'h0,     1, 64'h00));

      foreach (vecs[k]) begin
         frame(vecs[k].cmd, vecs[k].addr, vecs[k].nbits, vecs[k].mosi, rx, any_hi);
         if (vecs[k].mode == 1) check(vecs[k].name, rx, vecs[k].exp);
         else if (vecs[k].mode == 2) check(vecs[k].name, 64'(any_hi), 64'd0);
      end

      // ---------------- Reset during RDATA (word 0, bit 4) ----------------
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      for (int i = 7; i >= 0; i--) tick(1'b0, 1'b0, 1'((8'h10 >> i) & 8'h1));
      tick(1'b0, 1'b0, 1'b0);                     // dummy edge
      tick(1'b0, 1'b0, 1'b0); check("mr_bit7", 64'(MISO), 64'd1);
      tick(1'b0, 1'b0, 1'b0); check("mr_bit6", 64'(MISO), 64'd0);
      tick(1'b0, 1'b0, 1'b0); check("mr_bit5", 64'(MISO), 64'd1);
      tick(1'b1, 1'b0, 1'b1);
      check("mr_rst_miso", 64'(MISO), 64'd0);
      check("mr_rst_busy", 64'(busy), 64'd0);
      tick(1'b0, 1'b1, 1'b0);
      frame(CMD_READ, 8'h10, 9, 64'h0, rx, any_hi);
      check("mr_reread", rx, 64'hA5);

      // ---------------- Randomized bursts vs model ----------------
      model_status = 8'h00;
      for (int it = 0; it < 24; it++) begin
         int          a, n, part;
         logic [63:0] wbits, exp;
         a     = $urandom_range(8'h30, 8'hE0);
         n     = $urandom_range(1, 3);
         part  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         wbits = '0;
         for (int w = 0; w < n; w++) begin
            logic [7:0] d;
            d = 8'($urandom);
            model_mem[a + w] = d;
            wbits = (wbits << 8) | 64'(d);
         end
         if (part != 0) begin
            wbits = (wbits << part) | 64'($urandom_range(0, (1 << part) - 1));
            model_status[STAT_PARTIAL] = 1'b1;
         end
         frame(CMD_WRITE, 8'(a), 8 * n + part, wbits, rx, any_hi);
         exp = '0;
         for (int w = 0; w < n; w++) exp = (exp << 8) | 64'(model_mem[a + w]);
         frame(CMD_READ, 8'(a), 1 + 8 * n, 64'h0, rx, any_hi);
         check("rnd_read", rx, exp);
      end
      frame(CMD_STATUS, 8'h00, 9, 64'h0, rx, any_hi);
      check("rnd_status", rx, 64'(model_status));
      frame(CMD_STATUS, 8'h00, 9, 64'h0, rx, any_hi);
      check("rnd_status_clr", rx, 64'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/spi_mem_bridge.md
# spi_mem_bridge

SPI-slave-to-memory bridge with parametrised data width, address width and burst transfers. Successor to the fixed 8-bit SPI slave + RAM pair. One SPI frame carries a command and a start address, then any number of data words; the address auto-increments per word. MOSI/SS_n are sampled on the system clock, and a sticky status register is readable over SPI.

## Interface
- DW, 8: data word width in bits (≥2)
- AW, 8: address width; memory depth = 2^AW words
- clk  in  1  system clock; all activity on rising edge
- rst  in  1  synchronous, active-high reset
- SS_n  in  1  slave select, active low
- MOSI  in  1  serial data in, MSB first
- MISO  out  1  serial data out, MSB first
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- Frame: CMD (2 bits), then ADDR (AW bits, WRITE/READ only), then payload. All fields are MSB first, one bit per clk.
- CMD encoding:
  - 00 WRITE burst
  - 01 READ burst
  - 10 STATUS read (no ADDR field)
  - 11 reserved
- FSM states: IDLE, CMD, ADDR, WDATA, RDUMMY, RDATA, SDUMMY, SDATA, DROP.
  - IDLE→CMD: at an edge with SS_n=0; MOSI at that edge is CMD[1].
  - CMD→ADDR (00/01), SDUMMY (10), or DROP (11), after CMD[0].
  - ADDR→WDATA or RDUMMY after the AW-th address bit.
- WDATA:
  - Shift DW bits.
  - On the edge sampling the last bit, write mem[addr] and set addr←addr+1 (mod 2^AW).
  - The bit counter restarts; the burst continues without gaps.
- READ:
  - RDUMMY is one cycle and performs the memory read.
  - RDATA shifts mem[addr] out, then mem[addr+1], and so on, back to back with no gap between words.
  - The next word is prefetched before the current word's last bit leaves.
- STATUS: SDUMMY is one cycle; SDATA shifts the 8-bit status; MISO then stays 0 until SS_n rises.
- DROP: all MOSI is ignored and MISO=0 until SS_n rises.
- Status register (sticky):
  - bit0: address wrapped (max→0) during a burst.
  - bit1: reserved command received.
  - bit2: a WRITE frame ended with a partial word.
  - bits 7:3 read 0.
  - All bits clear on the edge the 8th status bit is shifted; a set event on the same edge wins.
- SS_n=1 at any edge in any state → IDLE at that edge.
  - Partial write word is discarded (no memory write); partial address is discarded.
  - MISO←0.
- rst=1 → IDLE, MISO=0, busy=0, status=0, address/shift/counters cleared. Memory contents are NOT reset.
- rst has priority over SS_n and MOSI.

## Timing
- Let edge A be the edge sampling the last ADDR bit (READ), or CMD[0] (STATUS).
- Edge A+1 is the dummy edge.
- MISO updates at edge A+2+i to bit (DW−1−i) of word 0 (STATUS: bit 7−i). The master samples on the following falling edge.
- Word n bit j appears at edge A+2+n·DW+(DW−1−j).
- A write is visible in memory at the edge sampling the word's last bit. A READ frame starting on the next frame sees the new data.
- busy rises at the first SS_n=0 edge and falls at the edge SS_n=1 is sampled.
- Reset values: MISO=0, busy=0.
- Minimum SS_n high time between frames: 1 clk.

## Structure
- Package spi_mem_pkg:
  - state enum (spi_mem_state_e)
  - command constants CMD_WRITE/CMD_READ/CMD_STATUS/CMD_RSVD
  - status bit index constants
- Sub-module spi_mem_ram:
  - parametrised DW×2^AW single-port RAM
  - synchronous write, registered one-cycle read
  - no reset on the array
- Top: FSM, shift registers, bit counter, address counter, status register.

## Test plan
All scenarios use AW=8, DW=8.

1. Reset: rst=1 for 3 clks with random SS_n/MOSI → MISO=0 and busy=0 every cycle; a following STATUS read returns 0x00.
2. Write burst: CMD 00, ADDR 0x10, data 0xA5, 0x3C, then SS_n=1 → mem[0x10]=0xA5, mem[0x11]=0x3C, status=0x00.
3. Read burst: CMD 01, ADDR 0x10, 16 clocks of payload → MISO streams 1010_0101_0011_1100 starting at edge A+2, no gap between words.
4. Wrap: WRITE ADDR 0xFF, data 0x11, 0x22 → mem[0xFF]=0x11, mem[0x00]=0x22. A STATUS read returns 0x01; a second STATUS read returns 0x00.
5. Abort and reserved command:
   - WRITE ADDR 0x20, data 0x77 then 3 bits, then SS_n=1 → mem[0x20]=0x77, mem[0x21] unchanged, status bit2=1.
   - CMD 11 plus 16 bits → MISO=0 throughout, status bit1=1.
6. Reset mid-read: assert rst during RDATA, word 0 bit 4 → MISO=0 and IDLE at that edge. The next READ of 0x10 still returns 0xA5.
